// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and constants for the bit-serial adder.
//   state_e       : controller state encoding (IDLE / RUN / DONE), 2 bits
//   DEFAULT_WIDTH : default operand/result width
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder_gatelevel_module.sv
// full_adder_gatelevel_module: 1-bit full adder built from gate primitives.
//   a, b, cin : input bits
//   sum       : a ^ b ^ cin
//   cout      : majority(a, b, cin)
module full_adder_gatelevel_module (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    wire p;   // propagate
    wire g;   // generate
    wire pc;  // propagate AND carry-in

    xor u_x0 (p, a, b);
    xor u_x1 (sum, p, cin);
    and u_a0 (g, a, b);
    and u_a1 (pc, p, cin);
    or  u_o0 (cout, g, pc);

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder that time-multiplexes one
// gate-level full-adder cell, one bit pair per clock, LSB first.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, accepted when not busy (IDLE or DONE)
//   a, b, cin  : operands and carry-in, captured on acceptance
//   busy       : high while the serial addition runs
//   done       : one-cycle pulse, sum/cout valid
//   sum, cout  : registered result, held until the next completion
//   ovf        : signed overflow, only when SERIAL_ADDER_OVF_EN is defined
// Optional feature macro: SERIAL_ADDER_OVF_EN (adds the ovf port and flop).
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             fa_s;
    logic             fa_co;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] res_shift;

    full_adder_gatelevel_module u_fa (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .sum  (fa_s),
        .cout (fa_co)
    );

    // Start is only honoured outside RUN; in DONE it chains straight into RUN.
    assign accept = start && (state_q != RUN);
    assign last   = (state_q == RUN) && (cnt_q == LAST_BIT);

    // Result register fills from the MSB so the LSB-first bits land in place.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_shift = fa_s;
        end else begin : g_res_wn
            assign res_shift = {fa_s, res_sr_q[WIDTH-1:1]};
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode (from registered state only)
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    // Datapath next-state
    always_comb begin
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d    = ovf_q;
`endif
        if (accept) begin
            a_sr_d  = a;
            b_sr_d  = b;
            carry_d = cin;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            res_sr_d = res_shift;
            carry_d  = fa_co;
            cnt_d    = cnt_q + CW'(1);
            if (last) begin
                sum_d  = res_shift;
                cout_d = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                // carry_q here is the carry into the MSB.
                ovf_d  = carry_q ^ fa_co;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
